// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the ALU arbiter slice.
//   alu_op_t    : 2-bit ALU opcode (ADD, SUB, MUL, DIV)
//   arb_state_t : arbiter FSM states
//   ALU_DATA_W  : default operand/result width
//   rr_next()   : round-robin index increment with wrap
// Optional feature macro used by this slice: ALU_DIVZERO_TRAP_EN
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_DATA_W = 64;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_MUL = 2'b10,
      ALU_DIV = 2'b11
   } alu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_RESP
   } arb_state_t;

   // Index following idx in a ring of n entries.
   function automatic int rr_next(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Grants the first asserted request
// at or after ptr, wrapping modulo NUM_REQ. The pointer itself is owned by the
// parent.
// Ports:
//   req     in  NUM_REQ  request vector
//   ptr     in  ID_W     highest-priority index this cycle
//   gnt     out NUM_REQ  one-hot grant (zero when no request)
//   gnt_idx out ID_W     index of the granted request
//   gnt_any out 1        any request granted
// -----------------------------------------------------------------------------
module rr_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    gnt_idx,
   output logic               gnt_any
);

   always_comb begin
      logic [ID_W-1:0] idx;
      // NOTE: every output gets a default before the search so no path
      // through this block leaves a value unassigned (no latches).
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         idx = ID_W'((int'(ptr) + off) % NUM_REQ);
         if (!gnt_any && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = idx;
            gnt_any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one external combinational ALU among NUM_REQ requesters.
// FSM: IDLE (grant + latch operands) -> EXEC (capture alu_res) -> RESP (hold
// response until rsp_ready) -> IDLE. One op in flight, no bypass.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req_valid/req_ready    per-requester handshake (req_ready one-hot or 0)
//   req_op/req_a/req_b     flattened per-requester op and operands
//   alu_a/alu_b/alu_op     to the ALU, driven from latched registers
//   alu_res                from the ALU
//   rsp_valid/rsp_ready    response handshake
//   rsp_id/rsp_data        issuing requester and registered result
//   rsp_err                divide-by-zero flag
// Macro ALU_DIVZERO_TRAP_EN: when defined, DIV by zero returns all-ones with
// rsp_err=1; otherwise rsp_err is tied 0 and the ALU result passes through.
// -----------------------------------------------------------------------------
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = ALU_DATA_W,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*2-1:0]      req_op,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   output logic [DATA_W-1:0]         alu_a,
   output logic [DATA_W-1:0]         alu_b,
   output logic [1:0]                alu_op,
   input  logic [DATA_W-1:0]         alu_res,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      rsp_err
);

   arb_state_t        state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   id_q, id_d;
   alu_op_t           op_q, op_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [DATA_W-1:0] data_q, data_d;

   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    gnt_idx;
   logic               gnt_any;

   // Unpacked views of the flattened request buses.
   logic [1:0]        op_arr [NUM_REQ];
   logic [DATA_W-1:0] a_arr  [NUM_REQ];
   logic [DATA_W-1:0] b_arr  [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign op_arr[g] = req_op[g*2 +: 2];
      assign a_arr[g]  = req_a[g*DATA_W +: DATA_W];
      assign b_arr[g]  = req_b[g*DATA_W +: DATA_W];
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr (
      .req     (req_valid),
      .ptr     (rr_ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      id_d     = id_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      data_d   = data_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_any) begin
               id_d    = gnt_idx;
               op_d    = alu_op_t'(op_arr[gnt_idx]);
               a_d     = a_arr[gnt_idx];
               b_d     = b_arr[gnt_idx];
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            data_d = alu_res;
`ifdef ALU_DIVZERO_TRAP_EN
            if (op_q == ALU_DIV && b_q == '0) begin
               data_d = '1;
            end
`endif
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               // Just-served requester drops to lowest priority.
               rr_ptr_d = ID_W'(rr_next(int'(id_q), NUM_REQ));
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: operand/result registers are reset too, because they drive the
   // alu_* and rsp_* outputs directly and those must read 0 out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         id_q     <= '0;
         op_q     <= ALU_ADD;
         a_q      <= '0;
         b_q      <= '0;
         data_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the
         // pre-edge values regardless of statement order.
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         id_q     <= id_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         data_q   <= data_d;
      end
   end

`ifdef ALU_DIVZERO_TRAP_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if (state_q == ST_EXEC) begin
         err_d = (op_q == ALU_DIV) && (b_q == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign rsp_err = err_q;
`else
   assign rsp_err = 1'b0;
`endif

   // Grant is combinational in IDLE; masked during reset so all outputs read 0.
   assign req_ready = (state_q == ST_IDLE && !rst) ? gnt : '0;
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_id    = id_q;
   assign rsp_data  = data_q;
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_op    = op_q;

endmodule
